// File: rtl/rca_chunk_adder.sv
// rca_chunk_adder
//   Chunk-serial wide adder. Operands are captured over a valid/ready
//   handshake, then added W bits per clock through a short ripple-carry
//   slice, with the slice carry held in a register between cycles. The
//   G-bit sum and final carry-out are presented over a second handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operands valid          in_ready   block can accept operands
//   a, b       G-bit operands          cin        carry into bit 0
//   out_valid  result valid            out_ready  consumer accepts result
//   sum        G-bit registered result carry      registered carry out of bit G-1
//
// sum is written slice by slice in place, so it shows partial bits while
// out_valid is low; consumers must qualify on out_valid.
module rca_chunk_adder #(
  parameter int G = 128,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [G-1:0] a,
  input  logic [G-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [G-1:0] sum,
  output logic         carry
);

  localparam int N  = G / W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(N - 1);

  generate
    if ((G % W) != 0) begin : g_bad_width
      $error("rca_chunk_adder: G must be an integer multiple of W");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [G-1:0]  a_q, a_d;
  logic [G-1:0]  b_q, b_d;
  logic [G-1:0]  sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cy_q, cy_d;
  logic          carry_q, carry_d;

  logic [W-1:0]  a_slice;
  logic [W-1:0]  b_slice;
  logic [W:0]    slice_res;
  logic          last_slice;

  // One W-bit ripple-carry slice; bit W of the result is the slice carry-out.
  function automatic logic [W:0] slice_add(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic         ci);
    slice_add = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  // State register plus all datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      carry_q <= carry_d;
    end
  end

  // Current slice of the captured operands
  always_comb begin
    a_slice    = a_q[cnt_q*W +: W];
    b_slice    = b_q[cnt_q*W +: W];
    slice_res  = slice_add(a_slice, b_slice, cy_q);
    last_slice = (cnt_q == LAST_SLICE);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = a;
          b_d   = b;
          // The carry register seeds slice 0 with the captured cin.
          cy_d  = cin;
          cnt_d = '0;
        end
      end
      RUN: begin
        sum_d[cnt_q*W +: W] = slice_res[W-1:0];
        cy_d                = slice_res[W];
        if (last_slice) begin
          carry_d = slice_res[W];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs: handshake flags decode directly from the state register
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    sum       = sum_q;
    carry     = carry_q;
  end

endmodule
